word_clip_ctrl: RTL and testbench

//  Voice-activity sequencer for the word clipper datapath. Consumes one energy value per

---
 rtl/word_clip_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_word_clip_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/word_clip_ctrl.sv
// -----------------------------------------------------------------------------
// word_clip_ctrl
//   Voice-activity sequencer for the word clipper datapath. It takes one energy
//   value per audio frame and decides where a word starts and ends, using attack
//   qualification (a run of voiced frames before a word is confirmed) and hangover
//   (a run of unvoiced frames before a word is closed). It drives start/end/drop
//   strobes to the clipper buffer and hands the finished word length to a consumer.
//
//   Optional feature macro: WORD_CLIP_CTRL_STATS_EN adds saturating word and drop
//   counters (stat_words, stat_drops) with a synchronous clear input (stat_clr).
//
// Ports
//   ACLK, ARESETN      clock, asynchronous active-low reset
//   cfg_enable         run enable; low aborts a capture in progress
//   cfg_thresh         a frame is voiced when frm_energy > cfg_thresh
//   cfg_attack         voiced frames needed to confirm a word (0 acts as 1)
//   cfg_hang           unvoiced frames that end a word (0 acts as 1)
//   cfg_max_len        forced end length; 0 means 2^LEN_W-1
//   frm_valid          one-cycle strobe per frame, qualifies frm_energy
//   frm_energy         energy of the current frame
//   clip_start         pulse: clipper starts capturing at this frame
//   clip_drop          pulse: discard the capture
//   clip_end           pulse: capture closed, word kept
//   clip_active        high while in ATTACK, ACTIVE or HANG
//   word_valid         word length available; held until accepted
//   word_len           frames in the word, including hangover
//   word_ready         consumer accepts the word
//   stat_clr           (stats build) clears both counters
//   stat_words         (stats build) words kept, saturating
//   stat_drops         (stats build) captures dropped, saturating
//   state_dbg          current FSM state encoding
//
// Handshake: a word transfers on the cycle where word_valid and word_ready are
// both high. word_valid never depends on word_ready, and once raised it stays
// high with word_len stable until that transfer; word_ready while word_valid is
// low has no effect.
// -----------------------------------------------------------------------------
module word_clip_ctrl #(
   parameter int ENERGY_W = 32,
   parameter int LEN_W    = 16
) (
   input  logic                ACLK,
   input  logic                ARESETN,
   input  logic                cfg_enable,
   input  logic [ENERGY_W-1:0] cfg_thresh,
   input  logic [LEN_W-1:0]    cfg_attack,
   input  logic [LEN_W-1:0]    cfg_hang,
   input  logic [LEN_W-1:0]    cfg_max_len,
   input  logic                frm_valid,
   input  logic [ENERGY_W-1:0] frm_energy,
   output logic                clip_start,
   output logic                clip_drop,
   output logic                clip_end,
   output logic                clip_active,
   output logic                word_valid,
   output logic [LEN_W-1:0]    word_len,
   input  logic                word_ready,
`ifdef WORD_CLIP_CTRL_STATS_EN
   input  logic                stat_clr,
   output logic [15:0]         stat_words,
   output logic [15:0]         stat_drops,
`endif
   output logic [2:0]          state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ATTACK = 3'd1,
      S_ACTIVE = 3'd2,
      S_HANG   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

   state_t           state;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] run;

   logic             voiced;
   logic             in_word;
   logic [LEN_W-1:0] limit;
   logic [LEN_W-1:0] attack_eff;
   logic [LEN_W-1:0] hang_eff;
   logic [LEN_W-1:0] len_inc;
   logic [LEN_W-1:0] run_inc;
   logic             max_hit;
   logic             end_word;
   logic             drop_word;

   assign state_dbg = state;

   assign voiced     = (frm_energy > cfg_thresh);
   assign in_word    = (state == S_ATTACK) || (state == S_ACTIVE) || (state == S_HANG);
   assign limit      = (cfg_max_len == '0) ? '1  : cfg_max_len;
   assign attack_eff = (cfg_attack  == '0) ? ONE : cfg_attack;
   assign hang_eff   = (cfg_hang    == '0) ? ONE : cfg_hang;

   // len never passes the limit, so the increment cannot wrap even at limit 2^LEN_W-1.
   assign len_inc = (len >= limit) ? len : len + ONE;
   assign run_inc = (run == '1)    ? run : run + ONE;
   assign max_hit = (len_inc >= limit);

   // Word close: the max-length check wins over the voiced/unvoiced decision,
   // which also turns a still-qualifying ATTACK into a kept word.
   always_comb begin
      end_word = 1'b0;
      if (in_word && cfg_enable && frm_valid) begin
         if (max_hit)
            end_word = 1'b1;
         else if ((state == S_ACTIVE) && !voiced && (hang_eff <= ONE))
            end_word = 1'b1;
         else if ((state == S_HANG) && !voiced && (run_inc >= hang_eff))
            end_word = 1'b1;
      end
   end

   // Capture discard: disable aborts at once (no frame needed); a failed attack
   // drops on the unvoiced frame.
   always_comb begin
      drop_word = 1'b0;
      if (in_word) begin
         if (!cfg_enable)
            drop_word = 1'b1;
         else if (frm_valid && (state == S_ATTACK) && !voiced && !max_hit)
            drop_word = 1'b1;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state       <= S_IDLE;
         len         <= '0;
         run         <= '0;
         clip_start  <= 1'b0;
         clip_drop   <= 1'b0;
         clip_end    <= 1'b0;
         clip_active <= 1'b0;
         word_valid  <= 1'b0;
         word_len    <= '0;
      end else begin
         clip_start <= 1'b0;
         clip_drop  <= 1'b0;
         clip_end   <= 1'b0;

         if (end_word) begin
            state       <= S_DONE;
            len         <= len_inc;
            run         <= '0;
            clip_end    <= 1'b1;
            clip_active <= 1'b0;
            word_valid  <= 1'b1;
            word_len    <= len_inc;
         end else if (drop_word) begin
            state       <= S_IDLE;
            len         <= '0;
            run         <= '0;
            clip_drop   <= 1'b1;
            clip_active <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (cfg_enable && frm_valid && voiced) begin
                     clip_start  <= 1'b1;
                     clip_active <= 1'b1;
                     len         <= ONE;
                     run         <= ONE;
                     state       <= (attack_eff <= ONE) ? S_ACTIVE : S_ATTACK;
                  end
               end
               S_ATTACK: begin
                  // Unvoiced frames here are handled by drop_word.
                  if (cfg_enable && frm_valid) begin
                     len <= len_inc;
                     run <= run_inc;
                     if (run_inc >= attack_eff)
                        state <= S_ACTIVE;
                  end
               end
               S_ACTIVE: begin
                  if (cfg_enable && frm_valid) begin
                     len <= len_inc;
                     if (voiced) begin
                        run <= '0;
                     end else begin
                        run   <= ONE;
                        state <= S_HANG;
                     end
                  end
               end
               S_HANG: begin
                  if (cfg_enable && frm_valid) begin
                     len <= len_inc;
                     if (voiced) begin
                        run   <= '0;
                        state <= S_ACTIVE;
                     end else begin
                        run <= run_inc;
                     end
                  end
               end
               S_DONE: begin
                  // Frames and cfg_enable are ignored until the word is taken.
                  if (word_ready) begin
                     state      <= S_IDLE;
                     word_valid <= 1'b0;
                     len        <= '0;
                     run        <= '0;
                  end
               end
               default: begin
                  state       <= S_IDLE;
                  clip_active <= 1'b0;
                  word_valid  <= 1'b0;
                  len         <= '0;
                  run         <= '0;
               end
            endcase
         end
      end
   end

`ifdef WORD_CLIP_CTRL_STATS_EN
   // Counters follow the registered strobes so they agree with what the clipper saw.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         stat_words <= '0;
         stat_drops <= '0;
      end else if (stat_clr) begin
         stat_words <= '0;
         stat_drops <= '0;
      end else begin
         if (clip_end && (stat_words != 16'hFFFF))
            stat_words <= stat_words + 16'd1;
         if (clip_drop && (stat_drops != 16'hFFFF))
            stat_drops <= stat_drops + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_word_clip_ctrl.sv
module tb_word_clip_ctrl;

   localparam int ENERGY_W = 32;
   localparam int LEN_W    = 16;

   logic                ACLK;
   logic                ARESETN;
   logic                cfg_enable;
   logic [ENERGY_W-1:0] cfg_thresh;
   logic [LEN_W-1:0]    cfg_attack;
   logic [LEN_W-1:0]    cfg_hang;
   logic [LEN_W-1:0]    cfg_max_len;
   logic                frm_valid;
   logic [ENERGY_W-1:0] frm_energy;
   logic                clip_start;
   logic                clip_drop;
   logic                clip_end;
   logic                clip_active;
   logic                word_valid;
   logic [LEN_W-1:0]    word_len;
   logic                word_ready;
   logic [2:0]          state_dbg;
`ifdef WORD_CLIP_CTRL_STATS_EN
   logic                stat_clr;
   logic [15:0]         stat_words;
   logic [15:0]         stat_drops;
`endif

   int total;
   int bad;

   // ---------------- clock / reset ----------------
   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   word_clip_ctrl #(.ENERGY_W(ENERGY_W), .LEN_W(LEN_W)) dut (
      .ACLK        (ACLK),
      .ARESETN     (ARESETN),
      .cfg_enable  (cfg_enable),
      .cfg_thresh  (cfg_thresh),
      .cfg_attack  (cfg_attack),
      .cfg_hang    (cfg_hang),
      .cfg_max_len (cfg_max_len),
      .frm_valid   (frm_valid),
      .frm_energy  (frm_energy),
      .clip_start  (clip_start),
      .clip_drop   (clip_drop),
      .clip_end    (clip_end),
      .clip_active (clip_active),
      .word_valid  (word_valid),
      .word_len    (word_len),
      .word_ready  (word_ready),
`ifdef WORD_CLIP_CTRL_STATS_EN
      .stat_clr    (stat_clr),
      .stat_words  (stat_words),
      .stat_drops  (stat_drops),
`endif
      .state_dbg   (state_dbg)
   );

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- drivers ----------------
   // One frame, then sample strobes {start,end,drop,active} half a cycle after the edge.
   task automatic frame(input logic [31:0] e, input logic [3:0] exp, input string tag);
      @(negedge ACLK);
      frm_valid  = 1'b1;
      frm_energy = e;
      @(negedge ACLK);
      frm_valid  = 1'b0;
      check(tag, 32'({clip_start, clip_end, clip_drop, clip_active}), 32'(exp));
   endtask

   task automatic take_word(input string tag);
      @(negedge ACLK);
      word_ready = 1'b1;
      @(negedge ACLK);
      word_ready = 1'b0;
      check({tag, "_wv_low"}, 32'(word_valid), 32'd0);
      check({tag, "_idle"},   32'(state_dbg),  32'd0);
   endtask

   task automatic disable_drop(input string tag);
      @(negedge ACLK);
      cfg_enable = 1'b0;
      @(negedge ACLK);
      check({tag, "_strobes"}, 32'({clip_start, clip_end, clip_drop, clip_active}), 32'b0010);
      check({tag, "_idle"},    32'(state_dbg), 32'd0);
      cfg_enable = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      total       = 0;
      bad         = 0;
      ARESETN     = 1'b0;
      cfg_enable  = 1'b1;
      cfg_thresh  = 32'd100;
      cfg_attack  = 16'd3;
      cfg_hang    = 16'd2;
      cfg_max_len = 16'd0;
      frm_valid   = 1'b0;
      frm_energy  = '0;
      word_ready  = 1'b0;
`ifdef WORD_CLIP_CTRL_STATS_EN
      stat_clr    = 1'b0;
`endif
      #3;
      check("rst_outputs", 32'({clip_start, clip_end, clip_drop, clip_active, word_valid}), 32'd0);
      check("rst_len",     32'(word_len),  32'd0);
      check("rst_state",   32'(state_dbg), 32'd0);
      @(negedge ACLK);
      ARESETN = 1'b1;

      // 1: basic word, attack 3, hang 2
      frame(32'd50,  4'b0000, "t1_f1");
      frame(32'd200, 4'b1001, "t1_f2");
      frame(32'd200, 4'b0001, "t1_f3");
      frame(32'd200, 4'b0001, "t1_f4");
      frame(32'd200, 4'b0001, "t1_f5");
      frame(32'd10,  4'b0001, "t1_f6");
      frame(32'd10,  4'b0100, "t1_f7");
      repeat (3) @(negedge ACLK);
      check("t1_wv_held", 32'(word_valid), 32'd1);
      check("t1_len",     32'(word_len),   32'd6);
      take_word("t1");

      // 2: failed attack
      frame(32'd200, 4'b1001, "t2_f1");
      frame(32'd200, 4'b0001, "t2_f2");
      frame(32'd50,  4'b0010, "t2_f3");
      check("t2_idle",  32'(state_dbg),  32'd0);
      check("t2_no_wv", 32'(word_valid), 32'd0);

      // 3: hang 3 with re-entry into ACTIVE
      cfg_hang = 16'd3;
      frame(32'd200, 4'b1001, "t3_f1");
      frame(32'd200, 4'b0001, "t3_f2");
      frame(32'd200, 4'b0001, "t3_f3");
      frame(32'd200, 4'b0001, "t3_f4");
      frame(32'd10,  4'b0001, "t3_f5");
      frame(32'd10,  4'b0001, "t3_f6");
      frame(32'd200, 4'b0001, "t3_f7");
      check("t3_reenter", 32'(state_dbg), 32'd2);
      frame(32'd10,  4'b0001, "t3_f8");
      frame(32'd10,  4'b0001, "t3_f9");
      frame(32'd10,  4'b0100, "t3_f10");
      check("t3_len", 32'(word_len), 32'd10);
      take_word("t3");

      // 4: max length 5, attack 1
      cfg_max_len = 16'd5;
      cfg_attack  = 16'd1;
      cfg_hang    = 16'd2;
      frame(32'd500, 4'b1001, "t4_f1");
      frame(32'd500, 4'b0001, "t4_f2");
      frame(32'd500, 4'b0001, "t4_f3");
      frame(32'd500, 4'b0001, "t4_f4");
      frame(32'd500, 4'b0100, "t4_f5");
      frame(32'd500, 4'b0000, "t4_done_ign1");
      frame(32'd500, 4'b0000, "t4_done_ign2");
      check("t4_wv_held", 32'(word_valid), 32'd1);
      check("t4_len",     32'(word_len),   32'd5);
      take_word("t4");
      frame(32'd500, 4'b1001, "t4_restart");
      disable_drop("t4_dis");

      // 5: energy equal to threshold is unvoiced; attack 0 acts as 1
      cfg_max_len = 16'd0;
      cfg_attack  = 16'd0;
      frame(32'd100, 4'b0000, "t5_eq_thresh");
      frame(32'd101, 4'b1001, "t5_start");
      check("t5_att0_active", 32'(state_dbg), 32'd2);
      frame(32'd100, 4'b0001, "t5_to_hang");
      check("t5_hang", 32'(state_dbg), 32'd3);
      disable_drop("t5_dis");

`ifdef WORD_CLIP_CTRL_STATS_EN
      check("st_words", 32'(stat_words), 32'd3);
      check("st_drops", 32'(stat_drops), 32'd3);
      @(negedge ACLK);
      stat_clr = 1'b1;
      @(negedge ACLK);
      stat_clr = 1'b0;
      check("st_clr_words", 32'(stat_words), 32'd0);
      check("st_clr_drops", 32'(stat_drops), 32'd0);
`endif

      // 6: asynchronous reset mid-HANG
      cfg_attack = 16'd1;
      cfg_hang   = 16'd3;
      frame(32'd200, 4'b1001, "t6_f1");
      frame(32'd10,  4'b0001, "t6_f2");
      check("t6_in_hang", 32'(state_dbg), 32'd3);
      @(negedge ACLK);
      #2;
      ARESETN = 1'b0;
      #1;
      check("t6_rst_outputs", 32'({clip_start, clip_end, clip_drop, clip_active, word_valid}), 32'd0);
      check("t6_rst_state",   32'(state_dbg), 32'd0);
      @(negedge ACLK);
      ARESETN = 1'b1;
      frame(32'd200, 4'b1001, "t6_after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
